// File: rtl/peripheral_bus_arbiter_pkg.sv
// rtl/peripheral_bus_arbiter_pkg.sv - shared types and constants for the peripheral bus arbiter
//
// Purpose: FSM state and bus-op enums, default timeout, the forced read data
// returned on a timeout, and the round-robin wrap helper.
package peripheral_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Wide enough for any supported data bus; users slice the low DATA_WIDTH bits.
  localparam logic [255:0] TIMEOUT_READ_DATA = '1;

  // Index 'offset' places after 'last', wrapping modulo n.
  // last < n and 1 <= offset <= n, so one subtraction is enough.
  function automatic int rr_index(input int last, input int offset, input int n);
    return (last + offset >= n) ? (last + offset - n) : (last + offset);
  endfunction

endpackage

// File: rtl/peripheral_bus_arbiter_if.sv
// rtl/peripheral_bus_arbiter_if.sv - peripheral bus master-port interface
//
// Purpose: groups the single-transaction peripheral bus handshake.
// Ports (signals):
//   read_request, write_request : master -> slave, level, held for the access
//   address, write_data         : master -> slave, stable while a request is high
//   response                    : slave -> master, completion strobe
//   read_data                   : slave -> master, valid with response
interface peripheral_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_request;
  logic                  write_request;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  response;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output read_request, write_request, address, write_data,
    input  response, read_data
  );

  modport slave (
    input  read_request, write_request, address, write_data,
    output response, read_data
  );
endinterface

// File: rtl/peripheral_bus_arbiter_rr_arbiter.sv
// rtl/peripheral_bus_arbiter_rr_arbiter.sv - combinational round-robin picker
//
// Purpose: picks the first requesting index after last_grant, wrapping.
// Ports:
//   request      : in,  N-bit request vector
//   last_grant   : in,  index of the previously served requester
//   grant_onehot : out, one-hot pick (all zero when nothing requests)
//   grant_index  : out, index of the pick
//   valid        : out, high when some requester is picked
module rr_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_index,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    valid        = 1'b0;
    cand         = '0;
    // Scan from the farthest candidate to the nearest so the nearest
    // requester after last_grant is the one left standing.
    for (int off = N; off >= 1; off--) begin
      cand = IW'(rr_index(int'(last_grant), off, N));
      if (request[cand]) begin
        grant_index = cand;
        valid       = 1'b1;
      end
    end
    grant_onehot[grant_index] = valid;
  end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// rtl/peripheral_bus_arbiter.sv - round-robin arbiter sharing one peripheral bus master port
//
// Purpose: grants NUM_MASTERS requesters one at a time, runs exactly one bus
// transaction, and forces completion with an error after TIMEOUT_CYCLES.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   m_read_request  : in,  per-master read request (level)
//   m_write_request : in,  per-master write request (level, wins over read)
//   m_address       : in,  packed per-master address
//   m_write_data    : in,  packed per-master write data
//   m_response      : out, one-cycle completion pulse to the granted master
//   m_read_data     : out, captured read data, valid with m_response
//   timeout_error   : out, pulses with m_response when the access timed out
//   bus             : peripheral bus master port
module peripheral_bus_arbiter
  import peripheral_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_read_request,
  input  logic [NUM_MASTERS-1:0]            m_write_request,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data,
  output logic [NUM_MASTERS-1:0]            m_response,
  output logic [DATA_WIDTH-1:0]             m_read_data,
  output logic                              timeout_error,
  peripheral_bus_if.master                  bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  // The counter starts at 0 on the first ACCESS cycle, so this value marks
  // the TIMEOUT_CYCLES-th (last allowed) cycle of the access.
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          last_grant;
  logic [NUM_MASTERS-1:0] grant_onehot_q;
  logic [CW-1:0]          count;

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]          pick_index;
  logic                   pick_valid;
  bus_op_t                pick_op;
  logic                   access_end;

  assign request    = m_read_request | m_write_request;
  assign pick_op    = m_write_request[pick_index] ? OP_WRITE : OP_READ;
  assign access_end = bus.response || (count == LAST_COUNT);

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .request      (request),
    .last_grant   (last_grant),
    .grant_onehot (pick_onehot),
    .grant_index  (pick_index),
    .valid        (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      grant             <= '0;
      last_grant        <= IW'(NUM_MASTERS - 1);
      grant_onehot_q    <= '0;
      count             <= '0;
      m_response        <= '0;
      m_read_data       <= '0;
      timeout_error     <= 1'b0;
      bus.read_request  <= 1'b0;
      bus.write_request <= 1'b0;
      bus.address       <= '0;
      bus.write_data    <= '0;
    end else begin
      m_response    <= '0;
      timeout_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant             <= pick_index;
            grant_onehot_q    <= pick_onehot;
            bus.address       <= m_address[pick_index*ADDR_WIDTH +: ADDR_WIDTH];
            bus.write_data    <= m_write_data[pick_index*DATA_WIDTH +: DATA_WIDTH];
            bus.write_request <= (pick_op == OP_WRITE);
            bus.read_request  <= (pick_op == OP_READ);
            count             <= '0;
            state             <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          count <= count + CW'(1);
          // A response in the timeout cycle still counts as a normal completion.
          if (bus.response) begin
            m_read_data <= bus.read_data;
          end else if (count == LAST_COUNT) begin
            m_read_data   <= TIMEOUT_READ_DATA[DATA_WIDTH-1:0];
            timeout_error <= 1'b1;
          end
          if (access_end) begin
            m_response        <= grant_onehot_q;
            bus.read_request  <= 1'b0;
            bus.write_request <= 1'b0;
            state             <= S_DONE;
          end
        end
        S_DONE: begin
          // Requests are not looked at here, giving the served master a cycle
          // to drop its request before the next pick.
          last_grant <= grant;
          count      <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb/tb_peripheral_bus_arbiter.sv - self-checking bench for peripheral_bus_arbiter
module tb_peripheral_bus_arbiter;
  import peripheral_bus_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_read_request, m_write_request, m_response;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_write_data;
  logic [DW-1:0]   m_read_data;
  logic            timeout_error;

  peripheral_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  peripheral_bus_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .m_read_request(m_read_request), .m_write_request(m_write_request),
    .m_address(m_address), .m_write_data(m_write_data),
    .m_response(m_response), .m_read_data(m_read_data),
    .timeout_error(timeout_error), .bus(bus_if.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Stimulus knobs
  bit auto_m = 0;
  int p_start = 0, p_renew = 0, p_withdraw = 0, op_mode = -1;
  int force_delay = -1;
  bit spurious = 0;
  bit fix_rdata_en = 0;
  logic [DW-1:0] fix_rdata = '0;

  // Slave state
  bit s_active = 0;
  int s_cnt = 0, s_delay = 0;

  // Observations for directed checks
  int resp_pulses = 0, tmo_pulses = 0;
  bit saw_bus_rd = 0, saw_bus_wr = 0;
  logic [DW-1:0] last_tmo_rdata = '0;
  int obs_log[$];

  // Transaction-level reference: one transaction record plus the last grant.
  bit m_valid = 0, m_busy = 0, m_op_wr = 0, m_err = 0;
  int m_g = 0, m_last = N - 1, m_start = 0, m_resp_at = -1, m_after_rst = -1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;

  task automatic set_req(input int i, input int op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_read_request[i]  = (op == 0 || op == 2);
    m_write_request[i] = (op == 1 || op == 2);
    m_address[i*AW +: AW]    = a;
    m_write_data[i*DW +: DW] = d;
  endtask

  task automatic new_req(input int i);
    set_req(i, (op_mode >= 0) ? op_mode : int'($urandom_range(0, 2)), $urandom, $urandom);
  endtask

  task automatic drive_masters();
    for (int i = 0; i < N; i++) begin
      if (m_read_request[i] | m_write_request[i]) begin
        if (m_response[i]) begin
          if (int'($urandom_range(0, 99)) < p_renew) new_req(i);
          else set_req(i, -1, '0, '0);
        end else if (int'($urandom_range(0, 99)) < p_withdraw) set_req(i, -1, '0, '0);
      end else if (int'($urandom_range(0, 99)) < p_start) new_req(i);
    end
  endtask

  task automatic drive_slave();
    if (bus_if.read_request || bus_if.write_request) begin
      if (!s_active) begin
        s_active = 1;
        s_cnt    = 0;
        s_delay  = (force_delay >= 0) ? force_delay : int'($urandom_range(0, T + 1));
      end
      bus_if.response  = (s_cnt == s_delay);
      bus_if.read_data = fix_rdata_en ? fix_rdata : DW'($urandom);
      s_cnt++;
    end else begin
      s_active = 0;
      bus_if.response  = spurious && ($urandom_range(0, 3) == 0);
      bus_if.read_data = DW'($urandom);
    end
  endtask

  task automatic check_outputs();
    bit acc, done;
    if (!m_valid) return;
    if (m_response != 0) resp_pulses++;
    if (timeout_error) begin tmo_pulses++; last_tmo_rdata = m_read_data; end
    if (bus_if.read_request) saw_bus_rd = 1;
    if (bus_if.write_request) saw_bus_wr = 1;
    for (int i = 0; i < N; i++) if (m_response[i]) obs_log.push_back(i);
    if (cyc == m_after_rst) begin
      check("rst_bus_rd", bus_if.read_request, 0);
      check("rst_bus_wr", bus_if.write_request, 0);
      check("rst_resp", m_response, 0);
      check("rst_tmo", timeout_error, 0);
      check("rst_rdata", m_read_data, 0);
      check("rst_addr", bus_if.address, 0);
      check("rst_wdata", bus_if.write_data, 0);
    end else begin
      acc  = m_busy && cyc >= m_start && (m_resp_at < 0 || cyc < m_resp_at);
      done = m_busy && m_resp_at == cyc;
      check("bus_rd", bus_if.read_request, acc && !m_op_wr);
      check("bus_wr", bus_if.write_request, acc && m_op_wr);
      check("m_resp", m_response, done ? (64'd1 << m_g) : 64'd0);
      check("tmo", timeout_error, done && m_err);
      if (acc) check("bus_addr", bus_if.address, m_addr);
      if (acc && m_op_wr) check("bus_wdata", bus_if.write_data, m_wd);
      if (done && (!m_op_wr || m_err)) check("rdata", m_read_data, m_rd);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_valid = 1; m_busy = 0; m_last = N - 1; m_after_rst = cyc + 1;
    end else if (m_valid) begin
      if (m_busy && m_resp_at == cyc) begin
        m_busy = 0; m_last = m_g;
      end else if (m_busy && m_resp_at < 0 && cyc >= m_start) begin
        if (bus_if.response) begin
          m_resp_at = cyc + 1; m_err = 0; m_rd = bus_if.read_data;
        end else if (cyc - m_start == T - 1) begin
          m_resp_at = cyc + 1; m_err = 1; m_rd = '1;
        end
      end else if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int i = (m_last + k) % N;
          if (!m_busy && (m_read_request[i] || m_write_request[i])) begin
            m_busy = 1; m_g = i; m_op_wr = m_write_request[i];
            m_addr = m_address[i*AW +: AW]; m_wd = m_write_data[i*DW +: DW];
            m_start = cyc + 1; m_resp_at = -1; m_err = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    if (auto_m) drive_masters();
    drive_slave();
    @(negedge clk);
    check_outputs();
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    resp_pulses = 0; tmo_pulses = 0; saw_bus_rd = 0; saw_bus_wr = 0; obs_log.delete();
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (k < budget) begin
      for (int i = 0; i < N; i++) if (m_response[i]) set_req(i, -1, '0, '0);
      if ((m_read_request | m_write_request) == 0 && !bus_if.read_request &&
          !bus_if.write_request && m_response == 0) break;
      step();
      k++;
    end
    check("idle_budget", k < budget, 1);
  endtask

  initial begin
    rst = 1;
    m_read_request = '0; m_write_request = '0; m_address = '0; m_write_data = '0;
    bus_if.response = 0; bus_if.read_data = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;

    // Single read, zero-wait slave
    clear_obs();
    force_delay = 0; fix_rdata_en = 1; fix_rdata = 32'hCAFE_F00D;
    set_req(0, 0, 32'h1000_0004, '0);
    step();
    check("c1_bus_rd", bus_if.read_request, 1);
    check("c1_addr", bus_if.address, 32'h1000_0004);
    step();
    check("c2_resp", m_response, 2'b01);
    check("c2_rdata", m_read_data, 32'hCAFE_F00D);
    check("c2_bus_rd", bus_if.read_request, 0);
    run_until_idle(10);
    fix_rdata_en = 0;

    // Contention from reset: both masters keep writing
    rst = 1; step(); rst = 0;
    clear_obs();
    auto_m = 1; p_start = 100; p_renew = 100; p_withdraw = 0; op_mode = 1; force_delay = -1;
    for (int k = 0; k < 300 && obs_log.size() < 5; k++) step();
    auto_m = 0;
    check("cont_count", obs_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < obs_log.size(); k++) check("cont_order", obs_log[k], k % 2);
    set_req(0, -1, '0, '0); set_req(1, -1, '0, '0);
    run_until_idle(40);

    // Wait states
    clear_obs();
    force_delay = 5;
    set_req(1, 1, 32'h2000_0010, 32'h1234_5678);
    run_until_idle(30);
    check("ws_pulses", resp_pulses, 1);

    // Timeout on both masters
    clear_obs();
    force_delay = 100;
    set_req(0, 0, 32'h3000_0000, '0);
    set_req(1, 0, 32'h3000_0004, '0);
    run_until_idle(60);
    check("tmo_pulses", tmo_pulses, 2);
    check("tmo_resp", resp_pulses, 2);
    check("tmo_rdata", last_tmo_rdata, 32'hFFFF_FFFF);

    // Response in the timeout cycle wins
    clear_obs();
    force_delay = T - 1;
    set_req(0, 0, 32'h3000_0008, '0);
    run_until_idle(30);
    check("coinc_tmo", tmo_pulses, 0);
    check("coinc_resp", resp_pulses, 1);

    // Read+write both high: write wins
    clear_obs();
    force_delay = 1;
    set_req(1, 2, 32'h4000_0000, 32'hA5A5_5A5A);
    run_until_idle(20);
    check("rw_no_rd", saw_bus_rd, 0);
    check("rw_wr", saw_bus_wr, 1);

    // Spurious responses while idle
    clear_obs();
    spurious = 1;
    for (int k = 0; k < 20; k++) step();
    spurious = 0;
    check("spur_resp", resp_pulses, 0);

    // Reset during ACCESS, then master 0 has priority again
    force_delay = 2;
    set_req(0, 0, 32'h5000_0000, '0);
    run_until_idle(20);
    force_delay = 100;
    set_req(1, 0, 32'h5000_0004, '0);
    step(); step(); step();
    rst = 1; set_req(1, -1, '0, '0);
    step();
    rst = 0;
    check("rrst_resp", m_response, 0);
    check("rrst_bus_rd", bus_if.read_request, 0);
    clear_obs();
    force_delay = 0;
    set_req(0, 0, 32'h5000_0008, '0);
    set_req(1, 0, 32'h5000_000C, '0);
    run_until_idle(40);
    check("rrst_count", obs_log.size(), 2);
    if (obs_log.size() >= 2) begin
      check("rrst_first", obs_log[0], 0);
      check("rrst_second", obs_log[1], 1);
    end

    // Randomized traffic with occasional resets
    auto_m = 1; p_start = 30; p_renew = 40; p_withdraw = 2; op_mode = -1;
    force_delay = -1; spurious = 1;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 0; auto_m = 0; spurious = 0;
    set_req(0, -1, '0, '0); set_req(1, -1, '0, '0);
    run_until_idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/peripheral_bus_arbiter.md
Name: peripheral_bus_arbiter

Overview:
Shares the single master port of the peripheral bus between NUM_MASTERS requesters, for example the CPU data port and a DMA engine. Requesters are granted one at a time in round-robin order, and exactly one transaction is in flight. A per-transaction timeout counter keeps a silent slave from hanging the bus: it completes the transaction with an error pulse. The block sits between the requesters and the peripheral bus decoder.

Parameters:
NUM_MASTERS, 2, number of requesters (2..4)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before a forced completion (>=1)

Ports:
clk  input  1  clock, all logic is rising-edge
rst  input  1  synchronous reset, active-high
m_read_request  input  NUM_MASTERS  per-master read request, level, held until that master's response
m_write_request  input  NUM_MASTERS  per-master write request, level, held until that master's response
m_address  input  NUM_MASTERS*ADDR_WIDTH  packed per-master address, master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
m_write_data  input  NUM_MASTERS*DATA_WIDTH  packed per-master write data
m_response  output  NUM_MASTERS  one-cycle completion pulse per master
m_read_data  output  DATA_WIDTH  read data, valid while any m_response bit is high
bus_read_request  output  1  to peripheral bus read_request
bus_write_request  output  1  to peripheral bus write_request
bus_address  output  ADDR_WIDTH  to peripheral bus address
bus_write_data  output  DATA_WIDTH  to peripheral bus write_data
bus_response  input  1  from peripheral bus response
bus_read_data  input  DATA_WIDTH  from peripheral bus read_data
timeout_error  output  1  one-cycle pulse, coincident with m_response, when a transaction timed out

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, grant=0, timeout counter=0, last_grant=NUM_MASTERS-1, so master 0 has first priority.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and the bus requests drop on the next cycle.
- FSM state IDLE:
  - A master is requesting when its read or write request is high.
  - If any master is requesting, the round-robin pick is the first requesting index after last_grant, wrapping modulo NUM_MASTERS.
  - On the pick, the block latches grant, address, write data and op (write if the write request is high; write wins if both are high), then moves to ACCESS.
- FSM state ACCESS:
  - bus_read_request or bus_write_request is registered high for the whole state, per the latched op. bus_address and bus_write_data are driven from the latches and stay stable.
  - The timeout counter increments each cycle.
  - When bus_response is high, the block captures bus_read_data into m_read_data, drops the bus request on the next cycle, and moves to DONE.
  - When the counter reaches TIMEOUT_CYCLES without a response, m_read_data is set to all ones, timeout_error is set, and the block moves to DONE.
  - If bus_response and the timeout occur in the same cycle, the response wins: no error.
- FSM state DONE:
  - m_response[grant] is high for exactly one cycle, with m_read_data valid.
  - last_grant=grant and the counter clears.
  - All requests are ignored this cycle, so a requester can drop its request without being re-granted. The FSM returns to IDLE.
- bus_response outside ACCESS is ignored.
- Latency: request high at cycle 0 -> bus request high from cycle 1 -> with a zero-wait slave responding in cycle 1, m_response at cycle 2. A back-to-back grant to another master has its bus request at cycle 4.
- m_read_data holds its last value outside DONE. It is all ones after a timeout; after a write it is undefined, and the bench must not check it.
- A request withdrawn before grant is simply not granted. A request withdrawn after grant is still completed on the bus.

Decomposition:
- Shared package peripheral_bus_pkg holds:
  - enum arb_state_t {IDLE, ACCESS, DONE}
  - constants DEFAULT_TIMEOUT=255 and TIMEOUT_READ_DATA='1
  - typedef bus_op_t {OP_READ, OP_WRITE}
- One sub-module rr_arbiter (parameter N): inputs request vector and last_grant, outputs one-hot/indexed grant and a valid flag. It is purely combinational and reusable for other shared resources.

Test Plan:
- Single read, zero-wait slave: master 0 reads 0x1000_0004, slave returns 0xCAFE_F00D in the same cycle -> bus_read_request high at cycle 1 only, m_response[0] at cycle 2, m_read_data=0xCAFE_F00D.
- Contention: masters 0 and 1 request writes simultaneously from reset -> master 0 is served first, then master 1. Repeat with both still requesting -> order alternates 1,0,1 and neither master is starved.
- Wait states: slave responds 5 cycles after the request -> address and write data are stable for all 5 cycles, and exactly one m_response pulse is issued.
- Timeout: TIMEOUT_CYCLES=8, slave never responds -> m_response and timeout_error pulse together, m_read_data=0xFFFF_FFFF, next master granted afterwards. Separately, response in the same cycle as the timeout -> no error.
- Read+write both high on master 1 -> only bus_write_request is asserted. Spurious bus_response during IDLE -> no m_response.
- rst asserted during ACCESS -> the next cycle shows all outputs 0 with no m_response. After release, master 0 has priority.
